// File: rtl/addseq_pkg.sv
// Shared constants and types for the adder-tree sequencer: widths, pass count,
// FSM state encoding and the operand array type.
package addseq_pkg;

    localparam int DATA_W    = 14;
    localparam int NUM_IN    = 16;
    localparam int NUM_LANES = 8;
    localparam int PASSES    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [DATA_W-1:0] vec16_t [NUM_IN];
    typedef logic [DATA_W-1:0] vec8_t  [NUM_LANES];

    // Lane j holds a real partial sum in a pass only while j < 8 >> pass.
    function automatic logic lane_active(input logic [1:0] pass, input int lane);
        return lane < (NUM_LANES >> pass);
    endfunction

    function automatic logic carry_out(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DATA_W];
    endfunction

endpackage

// File: rtl/adder_tree_sequencer_if.sv
// Producer/consumer handshake bundle of the sequencer. The ovf flag exists only
// when ADDSEQ_OVF_EN is defined.
interface adder_tree_sequencer_if;
    import addseq_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     busy;
`ifdef ADDSEQ_OVF_EN
    logic                     ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, ovf
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif

endinterface

// File: rtl/pair_add_stage.sv
// One level of the reduction tree: eight combinational pairwise adders,
// o_sums[j] = i_ops[2j] + i_ops[2j+1], wrapping modulo 2^DATA_W.
module pair_add_stage
    import addseq_pkg::*;
(
    input  vec16_t i_ops,
    output vec8_t  o_sums
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign o_sums[g] = i_ops[2*g] + i_ops[2*g+1];
    end

endmodule

// File: rtl/adder_tree_sequencer.sv
// Reduces 16 operands to one sum in four passes through a shared 8-lane adder
// stage. Optional sticky carry flag is built when ADDSEQ_OVF_EN is defined.
module adder_tree_sequencer
    import addseq_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    adder_tree_sequencer_if.slave  bus
);

    state_t     r_state;
    logic [1:0] r_pass_cnt;
    vec16_t     r_regs;
    logic       r_in_ready;
    logic       r_out_valid;
    logic       r_busy;

    vec16_t     w_operands;
    vec8_t      w_sums;
    logic       w_accept;

    // NOTE: combinational blocks assign every output on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_operands[i] = bus.in_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_accept = bus.in_valid && r_in_ready && (r_state == IDLE);

    pair_add_stage u_stage (
        .i_ops  (r_regs),
        .o_sums (w_sums)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_pass_cnt  <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            // NOTE: the register file is reset on purpose; out_data is observed straight from r_regs[0].
            for (int i = 0; i < NUM_IN; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_regs     <= w_operands;
                        r_pass_cnt <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= PASS;
                    end
                end
                PASS: begin
                    // Upper half r[8..15] keeps its contents; only lanes feed back.
                    for (int j = 0; j < NUM_LANES; j++) begin
                        r_regs[j] <= w_sums[j];
                    end
                    r_pass_cnt <= r_pass_cnt + 2'd1;
                    if (r_pass_cnt == 2'(PASSES - 1)) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_regs[0];
    assign bus.busy      = r_busy;

`ifdef ADDSEQ_OVF_EN
    logic [NUM_LANES-1:0] w_carry;
    logic                 r_ovf;

    // Carries from lanes beyond the live partial sums are ignored.
    always_comb begin
        for (int j = 0; j < NUM_LANES; j++) begin
            w_carry[j] = carry_out(r_regs[2*j], r_regs[2*j+1]) && lane_active(r_pass_cnt, j);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if ((r_state == PASS) && (|w_carry)) begin
            r_ovf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
`else
    // Overflow detection not built in this configuration.
`endif

endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Directed bench for adder_tree_sequencer: table of operand vectors plus
// hand-written stall, ignore and mid-pass reset sequences.
module tb_adder_tree_sequencer;
    import addseq_pkg::*;

    logic Clk = 1'b0;
    logic Reset;

    adder_tree_sequencer_if bus();

    adder_tree_sequencer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string                    name;
        logic [NUM_IN*DATA_W-1:0] data;
        logic [DATA_W-1:0]        exp_sum;
        logic                     exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NUM_IN*DATA_W-1:0] fill(input logic [DATA_W-1:0] even, input logic [DATA_W-1:0] odd);
        logic [NUM_IN*DATA_W-1:0] d;
        for (int i = 0; i < NUM_IN; i++) begin
            d[i*DATA_W +: DATA_W] = (i % 2 == 0) ? even : odd;
        end
        return d;
    endfunction

    function automatic logic [NUM_IN*DATA_W-1:0] ramp();
        logic [NUM_IN*DATA_W-1:0] d;
        for (int i = 0; i < NUM_IN; i++) begin
            d[i*DATA_W +: DATA_W] = DATA_W'(i);
        end
        return d;
    endfunction

    // Waits (bounded) for in_ready, then presents the vector for one accepting edge.
    task automatic send(input logic [NUM_IN*DATA_W-1:0] d);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_n++;
            tick();
            lat++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int busy_n;

        vecs[0] = '{"all_ones",   fill(14'd1, 14'd1),         14'd16,    1'b0};
        vecs[1] = '{"ramp",       ramp(),                      14'd120,   1'b0};
        vecs[2] = '{"all_max",    fill(14'd16383, 14'd16383), 14'd16368, 1'b1};
        vecs[3] = '{"all_1000",   fill(14'd1000, 14'd1000),   14'd16000, 1'b0};
        vecs[4] = '{"max_and_1",  fill(14'd16383, 14'd1),     14'd0,     1'b1};
        vecs[5] = '{"last_carry", fill(14'd1024, 14'd1024),   14'd0,     1'b1};
        vecs[6] = '{"five_seven", fill(14'd5, 14'd7),         14'd96,    1'b0};

        // Reset held with a competing in_valid: reset wins.
        Reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = fill(14'd3, 14'd3);
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
`ifdef ADDSEQ_OVF_EN
        check("rst_ovf",       32'(bus.ovf),       32'd0);
`endif
        Reset = 1'b0;
        tick();
        check("rst_release_no_accept", 32'(bus.busy),     32'd0);
        check("rst_release_in_ready",  32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;

        for (int v = 0; v < 7; v++) begin
            send(vecs[v].data);
            wait_result(lat, busy_n);
            check({vecs[v].name, "_latency"},  32'(lat),            32'd4);
            check({vecs[v].name, "_busy_cyc"}, 32'(busy_n),         32'd4);
            check({vecs[v].name, "_sum"},      32'(bus.out_data),   32'(vecs[v].exp_sum));
            check({vecs[v].name, "_busy_off"}, 32'(bus.busy),       32'd0);
            check({vecs[v].name, "_in_ready"}, 32'(bus.in_ready),   32'd0);
`ifdef ADDSEQ_OVF_EN
            check({vecs[v].name, "_ovf"},      32'(bus.ovf),        32'(vecs[v].exp_ovf));
`endif
            release_result();
        end

        // Consumer stall: result must hold steady while out_ready stays low.
        send(ramp());
        wait_result(lat, busy_n);
        for (int c = 0; c < 10; c++) begin
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_data",  32'(bus.out_data),  32'd120);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            tick();
        end
        release_result();

        // New vector and out_ready during PASS are both ignored.
        send(fill(14'd1, 14'd1));
        bus.in_valid  = 1'b1;
        bus.in_data   = fill(14'd2, 14'd2);
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("ignore_still_busy", 32'(bus.busy), 32'd1);
        wait_result(lat, busy_n);
        check("ignore_latency", 32'(lat),          32'd2);
        check("ignore_sum",     32'(bus.out_data), 32'd16);
        release_result();

        // Reset in the middle of the passes abandons the vector.
        send(ramp());
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data",  32'(bus.out_data),  32'd0);
        check("midrst_busy",      32'(bus.busy),      32'd0);
        tick();
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        for (int c = 0; c < 5; c++) tick();
        check("midrst_no_result", 32'(bus.out_valid), 32'd0);
        send(fill(14'd2, 14'd2));
        wait_result(lat, busy_n);
        check("midrst_latency", 32'(lat),          32'd4);
        check("midrst_sum",     32'(bus.out_data), 32'd32);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
